// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_pkg
//  Description : Shared M-extension definitions for the multiply/divide unit.
//                Holds the datapath width, the divider iteration count, the
//                M-op encoding, the execute-stage request struct and small
//                op-classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_div_pkg;

    localparam int XLEN           = 32;
    localparam int DIV_ITERATIONS = 32;
    localparam int DIV_CNT_W      = $clog2(DIV_ITERATIONS);

    typedef enum logic [3:0] {
        ALU_M_OPS_NONE   = 4'd0,
        ALU_M_OPS_MUL    = 4'd1,
        ALU_M_OPS_MULH   = 4'd2,
        ALU_M_OPS_MULHSU = 4'd3,
        ALU_M_OPS_MULHU  = 4'd4,
        ALU_M_OPS_DIV    = 4'd5,
        ALU_M_OPS_DIVU   = 4'd6,
        ALU_M_OPS_REM    = 4'd7,
        ALU_M_OPS_REMU   = 4'd8
    } type_alu_m_ops_e;

    typedef struct packed {
        logic [XLEN-1:0] alu_operand_1;
        logic [XLEN-1:0] alu_operand_2;
        type_alu_m_ops_e alu_m_ops;
    } type_exe2mul_s;

    // Any of DIV/DIVU/REM/REMU (everything that uses the iterative divider).
    function automatic logic is_div_op(input type_alu_m_ops_e op);
        return (op == ALU_M_OPS_DIV)  || (op == ALU_M_OPS_DIVU) ||
               (op == ALU_M_OPS_REM)  || (op == ALU_M_OPS_REMU);
    endfunction

    function automatic logic is_rem_op(input type_alu_m_ops_e op);
        return (op == ALU_M_OPS_REM) || (op == ALU_M_OPS_REMU);
    endfunction

    // Operand 1 is treated as two's complement for these ops.
    function automatic logic op1_is_signed(input type_alu_m_ops_e op);
        return (op == ALU_M_OPS_MUL)    || (op == ALU_M_OPS_MULH) ||
               (op == ALU_M_OPS_MULHSU) || (op == ALU_M_OPS_DIV)  ||
               (op == ALU_M_OPS_REM);
    endfunction

    // Operand 2 is treated as two's complement for these ops.
    function automatic logic op2_is_signed(input type_alu_m_ops_e op);
        return (op == ALU_M_OPS_MUL) || (op == ALU_M_OPS_MULH) ||
               (op == ALU_M_OPS_DIV) || (op == ALU_M_OPS_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Unsigned restoring radix-2 divider datapath. Produces one
//                quotient bit per i_step cycle; a 5-bit counter runs from
//                DIV_ITERATIONS-1 down to 0 and o_last flags the final step.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                i_start          - load dividend, clear remainder, arm counter
//                i_step           - perform one shift/subtract iteration
//                i_dividend       - dividend magnitude (sampled on i_start)
//                i_divisor        - divisor magnitude (held stable by caller)
//                o_quotient       - quotient magnitude after the last step
//                o_remainder      - remainder magnitude after the last step
//                o_last           - current step is the final iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import mul_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_last
);

    localparam logic [DIV_CNT_W-1:0] c_CNT_LOAD = DIV_CNT_W'(DIV_ITERATIONS - 1);

    // r_quo starts as the dividend; its MSB is shifted into the partial
    // remainder each step while the new quotient bit enters at the LSB.
    logic [XLEN-1:0]      r_quo;
    logic [XLEN-1:0]      r_rem;
    logic [DIV_CNT_W-1:0] r_cnt;

    logic [XLEN:0]        w_shift;
    logic [XLEN:0]        w_trial;
    logic                 w_fits;

    // The partial remainder is always below the divisor, so the shifted
    // value needs one extra bit and the trial difference never exceeds XLEN.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign w_fits  = ~w_trial[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_cnt <= c_CNT_LOAD;
        end else if (i_step) begin
            r_quo <= {r_quo[XLEN-2:0], w_fits};
            r_rem <= w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_last      = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mul_div.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div
//  Description : RV32M multiply/divide unit. Multiplies complete in two
//                cycles, divides run an iterative restoring divider followed
//                by a sign-fix cycle. Divide-by-zero always finishes early.
//  Ports       : clk          - clock, all state on rising edge
//                rst_n        - synchronous reset, ACTIVE-HIGH despite name
//                exe2mul_i    - operands and M-op from execute stage
//                mul_kill_i   - flush of the execute-stage instruction
//                mul_stall_o  - hold execute stage (combinational)
//                mul_valid_o  - one-cycle result strobe
//                mul_result_o - product / quotient / remainder (held)
//  Config      : M_DIV_EARLY_OUT_EN - when defined, divides with
//                |dividend| < |divisor| finish one cycle after the request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div
    import mul_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  type_exe2mul_s   exe2mul_i,
    input  logic            mul_kill_i,
    output logic            mul_stall_o,
    output logic            mul_valid_o,
    output logic [XLEN-1:0] mul_result_o
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_MUL  = 3'd1;
    localparam logic [2:0] c_ST_DIV  = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    logic [2:0]        r_state;
    type_alu_m_ops_e   r_op;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic              r_sign1;
    logic              r_sign2;
    logic [XLEN-1:0]   r_abs2;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;

    // ------------------------------------------------------------------
    // Request decode (IDLE-cycle view of the incoming operands)
    // ------------------------------------------------------------------
    logic              w_req;
    logic              w_accept;
    logic              w_in_is_div;
    logic              w_in_is_rem;
    logic              w_in_sign1;
    logic              w_in_sign2;
    logic [XLEN-1:0]   w_in_abs1;
    logic [XLEN-1:0]   w_in_abs2;
    logic              w_in_div_zero;
    logic              w_in_small;

    assign w_req         = (exe2mul_i.alu_m_ops != ALU_M_OPS_NONE);
    assign w_accept      = (r_state == c_ST_IDLE) && w_req && !mul_kill_i;
    assign w_in_is_div   = is_div_op(exe2mul_i.alu_m_ops);
    assign w_in_is_rem   = is_rem_op(exe2mul_i.alu_m_ops);
    // A sign bit is only set for operands interpreted as signed, so it also
    // serves directly as the 33rd (sign-extension) bit for the multiplier.
    assign w_in_sign1    = op1_is_signed(exe2mul_i.alu_m_ops) & exe2mul_i.alu_operand_1[XLEN-1];
    assign w_in_sign2    = op2_is_signed(exe2mul_i.alu_m_ops) & exe2mul_i.alu_operand_2[XLEN-1];
    assign w_in_abs1     = w_in_sign1 ? -exe2mul_i.alu_operand_1 : exe2mul_i.alu_operand_1;
    assign w_in_abs2     = w_in_sign2 ? -exe2mul_i.alu_operand_2 : exe2mul_i.alu_operand_2;
    assign w_in_div_zero = (exe2mul_i.alu_operand_2 == '0);

`ifdef M_DIV_EARLY_OUT_EN
    assign w_in_small    = (w_in_abs1 < w_in_abs2);
`else
    assign w_in_small    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Multiplier: operands sign-extended to 64 bits, so a plain 64-bit
    // product gives the correct signed/unsigned/mixed result.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;

    assign w_mul_a = {{XLEN{r_sign1}}, r_op1};
    assign w_mul_b = {{XLEN{r_sign2}}, r_op2};
    assign w_prod  = w_mul_a * w_mul_b;

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    logic              w_div_start;
    logic              w_div_step;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic              w_div_last;
    logic [XLEN-1:0]   w_quo_fixed;
    logic [XLEN-1:0]   w_rem_fixed;

    assign w_div_start = w_accept && w_in_is_div;
    assign w_div_step  = (r_state == c_ST_DIV);

    div_iter u_div_iter (
        .clk         (clk),
        .rst         (rst_n),
        .i_start     (w_div_start),
        .i_step      (w_div_step),
        .i_dividend  (w_in_abs1),
        .i_divisor   (r_abs2),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_last      (w_div_last)
    );

    // Quotient is negative when operand signs differ; the remainder follows
    // the dividend. Unsigned ops never carry a sign, so this is a no-op.
    assign w_quo_fixed = (r_sign1 ^ r_sign2) ? -w_div_quo : w_div_quo;
    assign w_rem_fixed = r_sign1 ? -w_div_rem : w_div_rem;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state  <= c_ST_IDLE;
            r_op     <= ALU_M_OPS_NONE;
            r_op1    <= '0;
            r_op2    <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_abs2   <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (mul_kill_i) begin
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_req) begin
                            r_op    <= exe2mul_i.alu_m_ops;
                            r_op1   <= exe2mul_i.alu_operand_1;
                            r_op2   <= exe2mul_i.alu_operand_2;
                            r_sign1 <= w_in_sign1;
                            r_sign2 <= w_in_sign2;
                            r_abs2  <= w_in_abs2;
                            if (!w_in_is_div) begin
                                r_state <= c_ST_MUL;
                            end else if (w_in_div_zero) begin
                                r_state  <= c_ST_DONE;
                                r_valid  <= 1'b1;
                                r_result <= w_in_is_rem ? exe2mul_i.alu_operand_1 : '1;
                            end else if (w_in_small) begin
                                r_state  <= c_ST_DONE;
                                r_valid  <= 1'b1;
                                r_result <= w_in_is_rem ? exe2mul_i.alu_operand_1 : '0;
                            end else begin
                                r_state <= c_ST_DIV;
                            end
                        end
                    end
                    c_ST_MUL: begin
                        r_state  <= c_ST_DONE;
                        r_valid  <= 1'b1;
                        r_result <= (r_op == ALU_M_OPS_MUL) ? w_prod[XLEN-1:0]
                                                            : w_prod[2*XLEN-1:XLEN];
                    end
                    c_ST_DIV: begin
                        if (w_div_last) begin
                            r_state <= c_ST_FIX;
                        end
                    end
                    c_ST_FIX: begin
                        r_state  <= c_ST_DONE;
                        r_valid  <= 1'b1;
                        r_result <= is_rem_op(r_op) ? w_rem_fixed : w_quo_fixed;
                    end
                    c_ST_DONE: begin
                        // The stalled request is still on the bus here; it
                        // belongs to the finished op and must not relaunch.
                        r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mul_stall_o  = w_accept ||
                          (r_state == c_ST_MUL) ||
                          (r_state == c_ST_DIV) ||
                          (r_state == c_ST_FIX);
    // A kill landing in the DONE cycle suppresses the strobe so a flushed
    // instruction never writes back.
    assign mul_valid_o  = r_valid && !mul_kill_i;
    assign mul_result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div
//  Description : Self-checking bench for mul_div. A driver issues requests
//                and pushes expected result/arrival cycle into a scoreboard;
//                a monitor pops and compares on every mul_valid_o strobe.
//                Define M_DIV_EARLY_OUT_EN for both bench and RTL together.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div;
    import mul_div_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    type_exe2mul_s   exe2mul_i;
    logic            mul_kill_i = 1'b0;
    logic            mul_stall_o;
    logic            mul_valid_o;
    logic [31:0]     mul_result_o;

    always #5 clk = ~clk;

    mul_div u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exe2mul_i    (exe2mul_i),
        .mul_kill_i   (mul_kill_i),
        .mul_stall_o  (mul_stall_o),
        .mul_valid_o  (mul_valid_o),
        .mul_result_o (mul_result_o)
    );

    typedef struct {
        logic [31:0]     res;
        int              cyc;
        type_alu_m_ops_e op;
        logic [31:0]     a;
        logic [31:0]     b;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t mon_it;
    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (plain RV32M arithmetic) ----------
    function automatic logic is_divide(input type_alu_m_ops_e op);
        case (op)
            ALU_M_OPS_DIV, ALU_M_OPS_DIVU, ALU_M_OPS_REM, ALU_M_OPS_REMU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input type_alu_m_ops_e op,
                                               input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        ia = a; ib = b;
        sa = ia; sb = ib; ub = b;
        case (op)
            ALU_M_OPS_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_M_OPS_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_M_OPS_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_M_OPS_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            ALU_M_OPS_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            ALU_M_OPS_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            ALU_M_OPS_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            ALU_M_OPS_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input type_alu_m_ops_e op,
                                       input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        int     ia, ib;
        if (!is_divide(op)) return 2;
        if (b == 0) return 1;
        ia = a; ib = b;
        if (op == ALU_M_OPS_DIV || op == ALU_M_OPS_REM) begin
            ma = ia; mb = ib;
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = a; mb = b;
        end
`ifdef M_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 34;
`endif
        return 34;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mul_valid_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got result 0x%08h required no strobe (cycle %0d)",
                         mul_result_o, cyc);
            end else begin
                mon_it = sb_q.pop_front();
                check($sformatf("result %s a=%08h b=%08h", mon_it.op.name(), mon_it.a, mon_it.b),
                      mul_result_o, mon_it.res);
                check($sformatf("latency %s a=%08h b=%08h", mon_it.op.name(), mon_it.a, mon_it.b),
                      32'(cyc), 32'(mon_it.cyc));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_req(input type_alu_m_ops_e op, input logic [31:0] a, input logic [31:0] b);
        exe2mul_i.alu_m_ops     = op;
        exe2mul_i.alu_operand_1 = a;
        exe2mul_i.alu_operand_2 = b;
    endtask

    // Issue one request at the next cycle, hold it until the strobe
    // (execute stage stalled), then return so the next one lands at DONE+1.
    task automatic run_op(input type_alu_m_ops_e op, input logic [31:0] a, input logic [31:0] b);
        sb_item_t it;
        logic     seen;
        @(posedge clk); #1;
        drive_req(op, a, b);
        it.res = ref_result(op, a, b);
        it.cyc = cyc + ref_latency(op, a, b);
        it.op  = op;
        it.a   = a;
        it.b   = b;
        sb_q.push_back(it);
        @(negedge clk);
        check("stall_on_request", {31'b0, mul_stall_o}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mul_valid_o) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout %s: got no strobe required one within 50 cycles", op.name());
            sb_q.delete();
        end else begin
            check("stall_in_done", {31'b0, mul_stall_o}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    int n0;

    initial begin
        drive_req(ALU_M_OPS_NONE, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_valid",  {31'b0, mul_valid_o}, 32'd0);
        check("reset_result", mul_result_o, 32'd0);
        check("reset_stall",  {31'b0, mul_stall_o}, 32'd0);

        // Directed cases
        run_op(ALU_M_OPS_MUL,   32'h00000007, 32'hFFFFFFFD);
        run_op(ALU_M_OPS_MULHU, 32'h00000007, 32'hFFFFFFFD);
        run_op(ALU_M_OPS_DIV,   32'hFFFFFFF9, 32'h00000002);
        run_op(ALU_M_OPS_REM,   32'hFFFFFFF9, 32'h00000002);
        run_op(ALU_M_OPS_DIVU,  32'd100,      32'd0);
        run_op(ALU_M_OPS_REMU,  32'd100,      32'd0);
        run_op(ALU_M_OPS_DIV,   32'h80000000, 32'hFFFFFFFF);
        run_op(ALU_M_OPS_REM,   32'h80000000, 32'hFFFFFFFF);
        run_op(ALU_M_OPS_DIVU,  32'd3,        32'd10);
        run_op(ALU_M_OPS_REMU,  32'd3,        32'd10);
        run_op(ALU_M_OPS_DIV,   32'd5,        32'hFFFFFFF9);
        run_op(ALU_M_OPS_MULHSU,32'hFFFFFFFF, 32'hFFFFFFFF);

        // Kill a divide in flight at N+10
        @(posedge clk); #1;
        drive_req(ALU_M_OPS_DIV, 32'hFFFFFFF9, 32'h2);
        repeat (10) @(posedge clk);
        #1 mul_kill_i = 1'b1;
        @(posedge clk); #1;
        mul_kill_i = 1'b0;
        drive_req(ALU_M_OPS_NONE, 32'h0, 32'h0);
        @(negedge clk);
        check("stall_after_kill", {31'b0, mul_stall_o}, 32'd0);
        repeat (40) @(posedge clk);

        // Back-to-back multiplies
        for (int i = 0; i < 6; i++)
            run_op(ALU_M_OPS_MULH, $urandom, $urandom);

        // Randomised mix
        for (int i = 0; i < 150; i++)
            run_op(type_alu_m_ops_e'($urandom_range(1, 8)), rand_operand(), rand_operand());

        // Reset mid-divide
        @(posedge clk); #1;
        drive_req(ALU_M_OPS_DIVU, 32'hDEADBEEF, 32'h3);
        n0 = cyc;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_req(ALU_M_OPS_NONE, 32'h0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("stall_after_reset",  {31'b0, mul_stall_o}, 32'd0);
        check("result_after_reset", mul_result_o, 32'd0);
        repeat (40) @(posedge clk);
        run_op(ALU_M_OPS_REMU, 32'hDEADBEEF, 32'h3);

        @(posedge clk); #1;
        drive_req(ALU_M_OPS_NONE, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
